// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point FFT datapath (frame loader,
// FFT core, power stage).
//   DATA_W   : width of one real or imaginary component
//   N_PT     : points per FFT frame
//   IDX_W    : width of a sample index within a frame
//   LAST_IDX : index of the final sample of a frame
//   cplx_t   : one complex sample {re, im}
//   frame_t  : one full frame of N_PT complex samples, natural order
package fft8_pkg;

  localparam int DATA_W = 24;
  localparam int N_PT   = 8;
  localparam int IDX_W  = $clog2(N_PT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PT - 1);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef cplx_t frame_t [N_PT];

endpackage

// File: rtl/fft8_bank.sv
// One N_PT-entry complex sample bank: single write port, full parallel read.
//   clk, rst          : clock, asynchronous active-high reset (clears bank)
//   we, idx           : write enable and entry index
//   wr_real, wr_imag  : sample written to entry idx when we=1
//   rd_real, rd_imag  : all entries, entry k at element k
module fft8_bank
  import fft8_pkg::*;
#(
  parameter int DATA_W = fft8_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wr_real,
  input  logic [DATA_W-1:0] wr_imag,
  output logic [DATA_W-1:0] rd_real [N_PT],
  output logic [DATA_W-1:0] rd_imag [N_PT]
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_PT; k++) begin
        rd_real[k] <= '0;
        rd_imag[k] <= '0;
      end
    end else if (we) begin
      rd_real[idx] <= wr_real;
      rd_imag[idx] <= wr_imag;
    end
  end

endmodule

// File: rtl/fft8_frame_loader.sv
// Packs a serial stream of complex samples into 8-sample frames using a
// ping-pong pair of banks and presents each completed frame on x0..x7 with
// a one-cycle en pulse for the FFT. Successive en pulses are at least GAP
// cycles apart.
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid/in_ready      : sample handshake
//   in_real, in_imag       : signed sample components (passed through as-is)
//   in_last                : end-of-frame marker; early in_last -> err, frame dropped
//   flush                  : discard the partially filled frame
//   en                     : one-cycle pulse, x0..x7 hold a new frame
//   x0..x7 _real/_imag     : frame samples in natural order, held until next en
//   frame_cnt              : frames issued, wraps
//   err                    : sticky short-frame flag, cleared only by rst
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered bank-full flags (and rst), never on
// in_valid; the source may hold in_valid with stable data until it transfers.
module fft8_frame_loader
  import fft8_pkg::*;
#(
  parameter int DATA_W = fft8_pkg::DATA_W,
  parameter int GAP    = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              in_last,
  input  logic              flush,
  output logic              en,
  output logic [DATA_W-1:0] x0_real,
  output logic [DATA_W-1:0] x1_real,
  output logic [DATA_W-1:0] x2_real,
  output logic [DATA_W-1:0] x3_real,
  output logic [DATA_W-1:0] x4_real,
  output logic [DATA_W-1:0] x5_real,
  output logic [DATA_W-1:0] x6_real,
  output logic [DATA_W-1:0] x7_real,
  output logic [DATA_W-1:0] x0_imag,
  output logic [DATA_W-1:0] x1_imag,
  output logic [DATA_W-1:0] x2_imag,
  output logic [DATA_W-1:0] x3_imag,
  output logic [DATA_W-1:0] x4_imag,
  output logic [DATA_W-1:0] x5_imag,
  output logic [DATA_W-1:0] x6_imag,
  output logic [DATA_W-1:0] x7_imag,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              err
);

  // After an issue the counter is loaded with GAP-1, so the next issue can
  // happen GAP edges later (GAP=1 allows back-to-back issues).
  localparam logic [7:0] GAP_RELOAD = 8'(GAP - 1);

  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [IDX_W-1:0]  wr_idx;
  logic [7:0]        gap_cnt;
  logic              accept;
  logic              keep;
  logic              issue;

  logic [DATA_W-1:0] bank0_real [N_PT];
  logic [DATA_W-1:0] bank0_imag [N_PT];
  logic [DATA_W-1:0] bank1_real [N_PT];
  logic [DATA_W-1:0] bank1_imag [N_PT];
  logic [DATA_W-1:0] x_real [N_PT];
  logic [DATA_W-1:0] x_imag [N_PT];

  assign in_ready = ~rst & ~full[wr_bank];
  assign accept   = in_valid & in_ready;
  // A sample arriving together with flush belongs to the discarded frame.
  assign keep     = accept & ~flush;
  assign issue    = full[rd_bank] & (gap_cnt == 8'd0);

  fft8_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (keep & ~wr_bank),
    .idx     (wr_idx),
    .wr_real (in_real),
    .wr_imag (in_imag),
    .rd_real (bank0_real),
    .rd_imag (bank0_imag)
  );

  fft8_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (keep & wr_bank),
    .idx     (wr_idx),
    .wr_real (in_real),
    .wr_imag (in_imag),
    .rd_real (bank1_real),
    .rd_imag (bank1_imag)
  );

  // Completion only targets a bank that is not full (in_ready), while issue
  // only targets a full bank, so the two full-flag updates never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      gap_cnt   <= 8'd0;
      en        <= 1'b0;
      frame_cnt <= '0;
      err       <= 1'b0;
      for (int k = 0; k < N_PT; k++) begin
        x_real[k] <= '0;
        x_imag[k] <= '0;
      end
    end else begin
      en <= issue;
      if (issue) begin
        for (int k = 0; k < N_PT; k++) begin
          x_real[k] <= rd_bank ? bank1_real[k] : bank0_real[k];
          x_imag[k] <= rd_bank ? bank1_imag[k] : bank0_imag[k];
        end
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
        frame_cnt     <= frame_cnt + CNT_W'(1);
        gap_cnt       <= GAP_RELOAD;
      end else if (gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end

      if (flush) begin
        wr_idx <= '0;
      end else if (accept) begin
        if (wr_idx == LAST_IDX) begin
          // in_last is optional on the final sample.
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= '0;
        end else if (in_last) begin
          wr_idx <= '0;
          err    <= 1'b1;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
    end
  end

  assign x0_real = x_real[0];
  assign x1_real = x_real[1];
  assign x2_real = x_real[2];
  assign x3_real = x_real[3];
  assign x4_real = x_real[4];
  assign x5_real = x_real[5];
  assign x6_real = x_real[6];
  assign x7_real = x_real[7];
  assign x0_imag = x_imag[0];
  assign x1_imag = x_imag[1];
  assign x2_imag = x_imag[2];
  assign x3_imag = x_imag[3];
  assign x4_imag = x_imag[4];
  assign x5_imag = x_imag[5];
  assign x6_imag = x_imag[6];
  assign x7_imag = x_imag[7];

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Bench for fft8_frame_loader. Two instances: dut 0 (GAP=4, CNT_W=16) and
// dut 1 (GAP=20, CNT_W=2). Stimulus is steered to one instance via sel.
// A per-instance reference model tracks accepted samples as frames, the
// number of frames waiting, and the earliest allowed issue time.
module tb_fft8_frame_loader;
  import fft8_pkg::*;

  localparam int W = 2 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              in_last;
  logic              flush;
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;
  int                sel;

  logic              vld_w   [2];
  logic              fl_w    [2];
  logic              ready_w [2];
  logic              en_w    [2];
  logic              err_w   [2];
  logic [DATA_W-1:0] xr_w    [2][N_PT];
  logic [DATA_W-1:0] xi_w    [2][N_PT];
  logic [15:0]       fc0;
  logic [1:0]        fc1;
  logic [15:0]       fc_w    [2];

  assign vld_w[0] = in_valid && (sel == 0);
  assign vld_w[1] = in_valid && (sel == 1);
  assign fl_w[0]  = flush && (sel == 0);
  assign fl_w[1]  = flush && (sel == 1);
  assign fc_w[0]  = fc0;
  assign fc_w[1]  = {14'b0, fc1};

  fft8_frame_loader #(.DATA_W(DATA_W), .GAP(4), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(vld_w[0]), .in_ready(ready_w[0]),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last), .flush(fl_w[0]),
    .en(en_w[0]),
    .x0_real(xr_w[0][0]), .x1_real(xr_w[0][1]), .x2_real(xr_w[0][2]), .x3_real(xr_w[0][3]),
    .x4_real(xr_w[0][4]), .x5_real(xr_w[0][5]), .x6_real(xr_w[0][6]), .x7_real(xr_w[0][7]),
    .x0_imag(xi_w[0][0]), .x1_imag(xi_w[0][1]), .x2_imag(xi_w[0][2]), .x3_imag(xi_w[0][3]),
    .x4_imag(xi_w[0][4]), .x5_imag(xi_w[0][5]), .x6_imag(xi_w[0][6]), .x7_imag(xi_w[0][7]),
    .frame_cnt(fc0), .err(err_w[0])
  );

  fft8_frame_loader #(.DATA_W(DATA_W), .GAP(20), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(vld_w[1]), .in_ready(ready_w[1]),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last), .flush(fl_w[1]),
    .en(en_w[1]),
    .x0_real(xr_w[1][0]), .x1_real(xr_w[1][1]), .x2_real(xr_w[1][2]), .x3_real(xr_w[1][3]),
    .x4_real(xr_w[1][4]), .x5_real(xr_w[1][5]), .x6_real(xr_w[1][6]), .x7_real(xr_w[1][7]),
    .x0_imag(xi_w[1][0]), .x1_imag(xi_w[1][1]), .x2_imag(xi_w[1][2]), .x3_imag(xi_w[1][3]),
    .x4_imag(xi_w[1][4]), .x5_imag(xi_w[1][5]), .x6_imag(xi_w[1][6]), .x7_imag(xi_w[1][7]),
    .frame_cnt(fc1), .err(err_w[1])
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [W-1:0]      part_q [2][$];
  logic [W-1:0]      exp_q  [2][$];
  logic [DATA_W-1:0] last_re [2][N_PT];
  logic [DATA_W-1:0] last_im [2][N_PT];
  int completed [2];
  int issued    [2];
  int since     [2];
  int en_cnt    [2];
  int en_gap    [2];
  int last_en   [2];
  bit exp_en    [2];
  bit err_m     [2];
  bit saw_low   [2];

  function automatic int gap_of(input int d);
    return (d == 0) ? 4 : 20;
  endfunction

  function automatic int cmod_of(input int d);
    return (d == 0) ? 65536 : 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic mon(input int d);
    int    pending;
    int    mism;
    cplx_t s;
    if (rst) begin
      chk($sformatf("rst_ready%0d", d), ready_w[d], 0);
      chk($sformatf("rst_en%0d", d), en_w[d], 0);
      chk($sformatf("rst_cnt%0d", d), fc_w[d], 0);
      chk($sformatf("rst_err%0d", d), err_w[d], 0);
      part_q[d].delete();
      exp_q[d].delete();
      completed[d] = 0;
      issued[d]    = 0;
      since[d]     = gap_of(d);
      exp_en[d]    = 1'b0;
      err_m[d]     = 1'b0;
      last_en[d]   = 0;
      for (int k = 0; k < N_PT; k++) begin
        last_re[d][k] = '0;
        last_im[d][k] = '0;
      end
      mism = 0;
      for (int k = 0; k < N_PT; k++)
        if (xr_w[d][k] !== '0 || xi_w[d][k] !== '0) mism++;
      chk($sformatf("rst_x%0d", d), mism, 0);
    end else begin
      chk($sformatf("en%0d", d), en_w[d], exp_en[d]);
      if (en_w[d]) begin
        en_cnt[d]++;
        if (last_en[d] > 0) en_gap[d] = cyc - last_en[d];
        last_en[d] = cyc;
        chk($sformatf("frame_avail%0d", d), exp_q[d].size() >= N_PT, 1);
        if (exp_q[d].size() >= N_PT) begin
          for (int k = 0; k < N_PT; k++) begin
            s = exp_q[d].pop_front();
            last_re[d][k] = s.re;
            last_im[d][k] = s.im;
          end
        end
        issued[d]++;
        chk($sformatf("frame_cnt%0d", d), fc_w[d], issued[d] % cmod_of(d));
        since[d] = 1;
      end else if (since[d] < 1000) begin
        since[d]++;
      end
      mism = 0;
      for (int k = 0; k < N_PT; k++)
        if (xr_w[d][k] !== last_re[d][k] || xi_w[d][k] !== last_im[d][k]) mism++;
      chk($sformatf("x_data%0d", d), mism, 0);
      chk($sformatf("err%0d", d), err_w[d], err_m[d]);
      pending = completed[d] - issued[d];
      chk($sformatf("ready%0d", d), ready_w[d], pending < 2);
      if (!ready_w[d]) saw_low[d] = 1'b1;
      // Decisions for the coming edge use the state before that edge.
      exp_en[d] = (pending > 0) && (since[d] >= gap_of(d));
      if (fl_w[d]) begin
        part_q[d].delete();
      end else if (vld_w[d] && pending < 2) begin
        part_q[d].push_back({in_real, in_imag});
        if (part_q[d].size() == N_PT) begin
          for (int k = 0; k < N_PT; k++) exp_q[d].push_back(part_q[d].pop_front());
          completed[d]++;
        end else if (in_last) begin
          part_q[d].delete();
          err_m[d] = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) mon(d);
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                      input logic last, input logic fl);
    int   budget;
    logic rdy;
    budget   = 0;
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    in_last  = last;
    flush    = fl;
    do begin
      @(negedge clk);
      rdy = ready_w[sel];
      @(posedge clk);
      #1;
      budget++;
    end while (!rdy && budget < 200);
    chk("send_accept", rdy, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send(DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input int d);
    int b;
    b = 0;
    while (completed[d] != issued[d] && b < 400) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk($sformatf("drain%0d", d), completed[d] - issued[d], 0);
    idle(gap_of(d) + 2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int mism;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    in_real = '0; in_imag = '0; sel = 0;
    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0; en_gap[d] = 0; saw_low[d] = 1'b0;
    end
    idle(3);
    rst = 1'b0;
    idle(1);

    // Single frame: real=k+1, imag=-(k+1); en one cycle after the last accept.
    for (int k = 0; k < N_PT; k++)
      send(DATA_W'(k + 1), DATA_W'(-(k + 1)), k == N_PT - 1, 1'b0);
    @(negedge clk);
    chk("lat_early", en_w[0], 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_en", en_w[0], 1);
    chk("x3_real", xr_w[0][3], 24'd4);
    chk("x3_imag", xi_w[0][3], 24'hFFFFFC);
    chk("cnt_one", fc_w[0], 1);
    @(posedge clk); #1;
    wait_drain(0);

    // Back-to-back frames with GAP=4: spacing set by the 8-sample fill.
    send_rand(16);
    wait_drain(0);
    chk("b2b_spacing", en_gap[0], 8);

    // Backpressure with GAP=20: four frames streamed continuously.
    sel = 1;
    base = issued[1];
    send_rand(32);
    wait_drain(1);
    chk("bp_frames", issued[1] - base, 4);
    chk("bp_stall", saw_low[1], 1);

    // Short frame on dut 0, then one good frame.
    sel = 0;
    base = issued[0];
    send_rand(3);
    send(DATA_W'($urandom), DATA_W'($urandom), 1'b1, 1'b0);
    idle(8);
    chk("short_err", err_w[0], 1);
    chk("short_no_en", issued[0] - base, 0);
    send_rand(8);
    wait_drain(0);
    chk("short_err_sticky", err_w[0], 1);
    chk("short_next", issued[0] - base, 1);

    // Flush after 5 samples, one sample dropped alongside a flush, then 8 new.
    base = issued[0];
    send_rand(5);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    send_rand(2);
    send(DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b1);
    send_rand(8);
    wait_drain(0);
    chk("flush_one_frame", issued[0] - base, 1);

    // Reset after 4 samples: no en until 8 fresh samples.
    send_rand(4);
    rst = 1'b1;
    idle(2);
    mism = 0;
    for (int k = 0; k < N_PT; k++)
      if (xr_w[0][k] !== '0 || xi_w[0][k] !== '0) mism++;
    chk("mid_rst_x", mism, 0);
    chk("mid_rst_err", err_w[0], 0);
    rst = 1'b0;
    base = en_cnt[0];
    idle(12);
    chk("no_en_after_rst", en_cnt[0] - base, 0);
    send_rand(8);
    wait_drain(0);
    chk("en_after_fresh", en_cnt[0] - base, 1);

    // frame_cnt wrap on the 2-bit counter: five frames -> 1.
    do_reset();
    sel = 1;
    send_rand(40);
    wait_drain(1);
    chk("wrap_cnt", fc_w[1], 1);

    // Randomized traffic on dut 0: idle gaps, occasional in_last and flush.
    sel = 0;
    for (int i = 0; i < 64; i++) begin
      idle($urandom_range(0, 2));
      send(DATA_W'($urandom), DATA_W'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    wait_drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
